// File: rtl/dll_discriminator_mc_pkg.sv
// -----------------------------------------------------------------------------
// dll_discriminator_mc_pkg
// Shared definitions for the multi-channel DLL discriminator:
//   - default parameter values (operand, scale, tag and queue widths)
//   - engine FSM state encoding (IDLE, NORM, MULT, DIV, DONE)
// No ports; imported by the interface, the top and the divider.
// -----------------------------------------------------------------------------
package dll_discriminator_mc_pkg;

  localparam int               DEF_I2Q2_WIDTH  = 38;
  localparam int               DEF_OP_WIDTH    = 10;
  localparam int               DEF_SCALE_WIDTH = 10;
  localparam logic [9:0]       DEF_SCALE       = 10'd768;  // C=3 in Q.8
  localparam int               DEF_SCALE_SHIFT = 8;
  localparam int               DEF_SHIFT_WIDTH = 8;
  localparam int               DEF_TAG_WIDTH   = 4;
  localparam int               DEF_FIFO_DEPTH  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NORM = 3'd1,
    ST_MULT = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } eng_state_e;

endpackage

// File: rtl/dll_discriminator_mc_if.sv
// -----------------------------------------------------------------------------
// dll_discriminator_mc_if
// Bundles the input handshake (in_valid/in_ready, tag, early/late I2Q2) and
// the result handshake (out_valid/out_ready, tag, direction, amount,
// div_zero) plus the busy flag.
//   master : producer/consumer side (drives inputs, out_ready)
//   slave  : the discriminator
// -----------------------------------------------------------------------------
interface dll_discriminator_mc_if
  import dll_discriminator_mc_pkg::*;
#(
  parameter int I2Q2_WIDTH  = DEF_I2Q2_WIDTH,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [TAG_WIDTH-1:0]   in_tag;
  logic [I2Q2_WIDTH-1:0]  i2q2_early;
  logic [I2Q2_WIDTH-1:0]  i2q2_late;
  logic                   out_valid;
  logic                   out_ready;
  logic [TAG_WIDTH-1:0]   result_tag;
  logic                   shift_direction;
  logic [SHIFT_WIDTH-1:0] shift_amount;
  logic                   div_zero;
  logic                   busy;

  modport master (
    output in_valid, in_tag, i2q2_early, i2q2_late, out_ready,
    input  in_ready, out_valid, result_tag, shift_direction, shift_amount,
           div_zero, busy
  );

  modport slave (
    input  in_valid, in_tag, i2q2_early, i2q2_late, out_ready,
    output in_ready, out_valid, result_tag, shift_direction, shift_amount,
           div_zero, busy
  );

endinterface

// File: rtl/dll_discriminator_mc_seq_divider.sv
// -----------------------------------------------------------------------------
// dll_discriminator_mc_seq_divider
// Restoring radix-2 divider, one quotient bit per cycle, MSB first.
// The cycle carrying start_i already performs the first iteration, so a
// division occupies exactly NUM_W cycles counted from the start cycle.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (control only)
//   start_i      : load numer_i/denom_i and run the first iteration
//   numer_i      : NUM_W-bit dividend
//   denom_i      : DEN_W-bit divisor
//   done_o       : high in the cycle that performs the last iteration
//   quotient_o   : result, forced to 0 when the divisor was 0
//   div_zero_o   : divisor of the current/last division was 0
// -----------------------------------------------------------------------------
module dll_discriminator_mc_seq_divider #(
  parameter int NUM_W = 20,
  parameter int DEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] numer_i,
  input  logic [DEN_W-1:0] denom_i,
  output logic             done_o,
  output logic [NUM_W-1:0] quotient_o,
  output logic             div_zero_o
);

  localparam int CNT_W = $clog2(NUM_W) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEN_W-1:0] rem_q, den_q;
  logic [NUM_W-1:0] num_q, quo_q;
  logic             dz_q;

  logic             step;
  logic [DEN_W-1:0] rem_in, den_in, rem_nx;
  logic [NUM_W-1:0] num_in, quo_nx;
  logic [DEN_W:0]   trial;
  logic             fits;

  always_comb begin
    step   = start_i || (cnt_q != '0);
    rem_in = start_i ? '0      : rem_q;
    num_in = start_i ? numer_i : num_q;
    den_in = start_i ? denom_i : den_q;
    trial  = {rem_in, num_in[NUM_W-1]};
    fits   = (trial >= {1'b0, den_in});
    // The remainder stays below the divisor, so dropping the top trial bit
    // is lossless whenever the divisor is non-zero.
    rem_nx = fits ? DEN_W'(trial - {1'b0, den_in}) : DEN_W'(trial);
    quo_nx = (start_i ? '0 : (quo_q << 1)) | NUM_W'(fits);
    cnt_d  = cnt_q;
    if (start_i) begin
      cnt_d = CNT_W'(NUM_W - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (step) begin
      rem_q <= rem_nx;
      num_q <= num_in << 1;
      quo_q <= quo_nx;
    end
    if (start_i) begin
      den_q <= denom_i;
      dz_q  <= (denom_i == '0);
    end
  end

  assign done_o     = (cnt_q == CNT_W'(1));
  assign quotient_o = dz_q ? '0 : quo_q;
  assign div_zero_o = dz_q;

endmodule

// File: rtl/dll_discriminator_mc.sv
// -----------------------------------------------------------------------------
// dll_discriminator_mc
// Multi-channel DLL discriminator. Tagged early/late I2Q2 pairs enter a small
// queue; a single engine computes shift = ((E-L)*K/(E+L)) >> SCALE_SHIFT via
// normalisation, a registered multiply and a sequential divider, returning
// results in push order with their tag.
// Ports:
//   clk           : system clock
//   global_reset  : synchronous, active-high reset
//   bus (slave)   : in_valid/in_ready/in_tag/i2q2_early/i2q2_late,
//                   out_valid/out_ready/result_tag/shift_direction/
//                   shift_amount/div_zero, busy
// Build option:
//   DLL_ROUND_EN  : round half-up before the final shift (else truncate)
// -----------------------------------------------------------------------------
module dll_discriminator_mc
  import dll_discriminator_mc_pkg::*;
#(
  parameter int                     I2Q2_WIDTH  = DEF_I2Q2_WIDTH,
  parameter int                     OP_WIDTH    = DEF_OP_WIDTH,
  parameter int                     SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter logic [SCALE_WIDTH-1:0] SCALE       = DEF_SCALE,
  parameter int                     SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int                     SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int                     TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int                     FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 global_reset,
  dll_discriminator_mc_if.slave bus
);

  localparam int Q_W   = OP_WIDTH + SCALE_WIDTH;
  localparam int ACC_W = Q_W + 1;
  localparam int S_W   = I2Q2_WIDTH + 1;
  localparam int IDX_W = $clog2(S_W) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [IDX_W-1:0] msb_index(input logic [S_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < S_W; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [SHIFT_WIDTH-1:0] round_sat(input logic [Q_W-1:0] quo);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] scaled;
    acc = {1'b0, quo};
`ifdef DLL_ROUND_EN
    acc = acc + (ACC_W'(1) << (SCALE_SHIFT - 1));
`endif
    scaled = acc >> SCALE_SHIFT;
    if (|scaled[ACC_W-1:SHIFT_WIDTH]) return '1;
    return scaled[SHIFT_WIDTH-1:0];
  endfunction

  // Input queue
  logic [TAG_WIDTH-1:0]  q_tag   [FIFO_DEPTH];
  logic [I2Q2_WIDTH-1:0] q_early [FIFO_DEPTH];
  logic [I2Q2_WIDTH-1:0] q_late  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;
  logic [I2Q2_WIDTH-1:0] head_e, head_l;

  eng_state_e state_q, state_d;
  logic       div_first_q, div_first_d;

  // in_ready depends only on the registered count, never on out_ready.
  assign bus.in_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == ST_IDLE) && (count_q != '0);
  assign head_e       = q_early[rd_ptr_q];
  assign head_l       = q_late[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    div_first_d = (state_q == ST_MULT);
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      div_first_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      div_first_q <= div_first_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_tag[wr_ptr_q]   <= bus.in_tag;
      q_early[wr_ptr_q] <= bus.i2q2_early;
      q_late[wr_ptr_q]  <= bus.i2q2_late;
    end
  end

  // Stage p0: pop, sum / |difference| / direction
  logic [S_W-1:0]        sum_p0;
  logic [I2Q2_WIDTH-1:0] diff_p0;
  logic                  dir_p0;
  logic [TAG_WIDTH-1:0]  tag_p0;

  always_ff @(posedge clk) begin
    if (pop) begin
      sum_p0  <= {1'b0, head_e} + {1'b0, head_l};
      diff_p0 <= (head_e >= head_l) ? (head_e - head_l) : (head_l - head_e);
      // Strict compare already yields 0 when E == L (D == 0).
      dir_p0  <= (head_l > head_e);
      tag_p0  <= q_tag[rd_ptr_q];
    end
  end

  // Stage p1: normalise both operands by the same shift so the ratio holds
  logic [IDX_W-1:0]    norm_idx, norm_sh;
  logic [OP_WIDTH-1:0] sum_p1, diff_p1;

  always_comb begin
    norm_idx = msb_index(sum_p0 | {1'b0, diff_p0});
    norm_sh  = '0;
    if (norm_idx >= IDX_W'(OP_WIDTH)) begin
      norm_sh = norm_idx - IDX_W'(OP_WIDTH - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_NORM) begin
      sum_p1  <= OP_WIDTH'(sum_p0 >> norm_sh);
      diff_p1 <= OP_WIDTH'({1'b0, diff_p0} >> norm_sh);
    end
  end

  // Stage p2: registered product D*K
  logic [Q_W-1:0] prod_p2;

  always_ff @(posedge clk) begin
    if (state_q == ST_MULT) begin
      prod_p2 <= Q_W'(diff_p1) * Q_W'(SCALE);
    end
  end

  // Divide stage: Q_W cycles, started on the first DIV cycle
  logic           div_start, div_done, div_dz;
  logic [Q_W-1:0] div_quo;

  assign div_start = (state_q == ST_DIV) && div_first_q;

  dll_discriminator_mc_seq_divider #(
    .NUM_W (Q_W),
    .DEN_W (OP_WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (global_reset),
    .start_i    (div_start),
    .numer_i    (prod_p2),
    .denom_i    (sum_p1),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .div_zero_o (div_dz)
  );

  // Engine control and result presentation
  always_comb begin
    state_d             = state_q;
    bus.out_valid       = 1'b0;
    bus.result_tag      = '0;
    bus.shift_direction = 1'b0;
    bus.shift_amount    = '0;
    bus.div_zero        = 1'b0;
    case (state_q)
      ST_IDLE: if (count_q != '0) state_d = ST_NORM;
      ST_NORM: state_d = ST_MULT;
      ST_MULT: state_d = ST_DIV;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: begin
        bus.out_valid       = 1'b1;
        bus.result_tag      = tag_p0;
        bus.shift_direction = dir_p0;
        bus.shift_amount    = round_sat(div_quo);
        bus.div_zero        = div_dz;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q != ST_IDLE) || (count_q != '0);

endmodule
